// File: rtl/poly_result_collector.sv
// Pops the result and status FIFOs in lockstep, re-pairs them onto a valid/ready output,
// keeps saturating pair/error counters and flags a sticky loss of pairing between the FIFOs.
// Optional build macro: POLY_COLLECT_DROP_ERR_EN (count error pairs but never forward them).
module poly_result_collector #(
    parameter int RESULT_WIDTH   = 32,
    parameter int STATUS_WIDTH   = 3,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [RESULT_WIDTH-1:0] result_in,
    input  logic                    result_empty,
    output logic                    result_read,
    input  logic [STATUS_WIDTH-1:0] status_in,
    input  logic                    status_empty,
    output logic                    status_read,
    output logic [RESULT_WIDTH-1:0] out_result,
    output logic [STATUS_WIDTH-1:0] out_status,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    clear,
    output logic [CNT_WIDTH-1:0]    pair_count,
    output logic [CNT_WIDTH-1:0]    error_count,
    output logic                    sync_error
);

    typedef enum logic {RUN, DESYNC} state_t;

    localparam int                  SKEW_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SKEW_W-1:0]   SKEW_LAST = SKEW_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SKEW_W-1:0]   SKEW_FULL = SKEW_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t              state, state_next;
    logic [SKEW_W-1:0]   skew_cnt, skew_next;
    logic                sync_error_next;
    logic                skewed, status_err, out_space, fifo_ready, pop, load;

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        skewed     = (result_empty != status_empty);
        status_err = (status_in != '0);
        out_space  = !out_valid || out_ready;
        fifo_ready = (state == RUN) && !result_empty && !status_empty && !clear && !reset;
`ifdef POLY_COLLECT_DROP_ERR_EN
        // Error pairs are discarded, so they never wait for output space.
        pop  = fifo_ready && (status_err || out_space);
        load = pop && !status_err;
`else
        pop  = fifo_ready && out_space;
        load = pop;
`endif
    end

    assign result_read = pop;
    assign status_read = pop;

    always_comb begin
        state_next      = state;
        skew_next       = skew_cnt;
        sync_error_next = sync_error;
        if (clear) begin
            state_next      = RUN;
            skew_next       = '0;
            sync_error_next = 1'b0;
        end else if (state == RUN) begin
            if (!skewed) begin
                skew_next = '0;
            end else if (skew_cnt == SKEW_LAST) begin
                state_next      = DESYNC;
                sync_error_next = 1'b1;
                skew_next       = SKEW_FULL;
            end else begin
                skew_next = skew_cnt + SKEW_W'(1);
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            skew_cnt   <= '0;
            sync_error <= 1'b0;
        end else begin
            state      <= state_next;
            skew_cnt   <= skew_next;
            sync_error <= sync_error_next;
        end
    end

    // Clear outranks a same-cycle pop for the counters; the output register ignores clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pair_count  <= '0;
            error_count <= '0;
        end else if (clear) begin
            pair_count  <= '0;
            error_count <= '0;
        end else if (pop) begin
            if (pair_count != CNT_MAX)
                pair_count <= pair_count + CNT_WIDTH'(1);
            if (status_err && (error_count != CNT_MAX))
                error_count <= error_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_status <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_result <= result_in;
            out_status <= status_in;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_result_collector.sv
// Randomised scoreboard bench for poly_result_collector: FIFOs modelled as queues, expected
// pairs derived by zipping the pushed result and status streams in order.
module tb_poly_result_collector;

    localparam int RW      = 32;
    localparam int SW      = 3;
    localparam int CW      = 8;
    localparam int TIMEOUT = 64;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        bit [RW-1:0] r;
        bit [SW-1:0] s;
    } pair_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [RW-1:0] result_in = '0;
    logic          result_empty = 1'b1;
    logic          result_read;
    logic [SW-1:0] status_in = '0;
    logic          status_empty = 1'b1;
    logic          status_read;
    logic [RW-1:0] out_result;
    logic [SW-1:0] out_status;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] pair_count;
    logic [CW-1:0] error_count;
    logic          sync_error;

    poly_result_collector #(
        .RESULT_WIDTH(RW), .STATUS_WIDTH(SW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .result_in(result_in), .result_empty(result_empty), .result_read(result_read),
        .status_in(status_in), .status_empty(status_empty), .status_read(status_read),
        .out_result(out_result), .out_status(out_status), .out_valid(out_valid),
        .out_ready(out_ready), .clear(clear),
        .pair_count(pair_count), .error_count(error_count), .sync_error(sync_error)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    bit [RW-1:0] res_q[$];
    bit [SW-1:0] st_q[$];
    bit [RW-1:0] mres[$];
    bit [SW-1:0] mst[$];
    pair_t       exp_q[$];
    int          model_pairs = 0;
    int          model_errs  = 0;

    int  cyc = 0;
    int  pop_cnt = 0;
    int  pop_cycles[$];
    bit  pop_pend = 1'b0;
    bit  rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic update_ports();
        result_empty = (res_q.size() == 0);
        result_in    = result_empty ? '0 : res_q[0];
        status_empty = (st_q.size() == 0);
        status_in    = status_empty ? '0 : st_q[0];
    endtask

    // Reference: the k-th result pairs with the k-th status, whatever the timing.
    task automatic zip();
        while (mres.size() > 0 && mst.size() > 0) begin
            pair_t p;
            p.r = mres.pop_front();
            p.s = mst.pop_front();
            if (model_pairs < CNT_MAX) model_pairs++;
            if (p.s != 0 && model_errs < CNT_MAX) model_errs++;
`ifdef POLY_COLLECT_DROP_ERR_EN
            if (p.s == 0) exp_q.push_back(p);
`else
            exp_q.push_back(p);
`endif
        end
    endtask

    task automatic push_res(input bit [RW-1:0] r);
        res_q.push_back(r);
        mres.push_back(r);
        zip();
        update_ports();
    endtask

    task automatic push_st(input bit [SW-1:0] s);
        st_q.push_back(s);
        mst.push_back(s);
        zip();
        update_ports();
    endtask

    task automatic push_pair(input bit [RW-1:0] r, input bit [SW-1:0] s);
        push_res(r);
        push_st(s);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || res_q.size() != 0 || st_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(name, (exp_q.size() == 0 && res_q.size() == 0 && st_q.size() == 0), 1);
    endtask

    // FIFO model: a pop seen before the edge is applied just after it.
    always @(negedge clock) begin
        pop_pend = result_read && !reset;
        if (pop_pend) begin
            pop_cnt++;
            pop_cycles.push_back(cyc);
        end
    end

    always @(posedge clock) begin
        cyc++;
        #1;
        if (pop_pend) begin
            if (res_q.size() != 0) void'(res_q.pop_front());
            if (st_q.size() != 0) void'(st_q.pop_front());
        end
        pop_pend = 1'b0;
        update_ports();
    end

    // Monitor: every accepted output pair is popped from the scoreboard and compared.
    always @(negedge clock) begin
        if (!reset) begin
            check("strobes_equal", result_read, status_read);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    check("out_result", out_result, e.r);
                    check("out_status", out_status, e.s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        update_ports();
        tick(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_status", out_status, 0);
        check("rst_pair_count", pair_count, 0);
        check("rst_error_count", error_count, 0);
        check("rst_sync_error", sync_error, 0);
        reset = 1'b0;
        tick();

        // Two pairs, continuous ready: back-to-back pops, order preserved.
        out_ready = 1'b1;
        pop_cycles.delete();
        push_pair(32'h0000_0019, 3'd0);
        push_pair(32'hFFFF_FFFF, 3'd3);
        wait_drain("drain_t2", 50);
        tick(2);
        check("t2_pops", pop_cycles.size(), 2);
        if (pop_cycles.size() == 2) check("t2_consecutive", pop_cycles[1] - pop_cycles[0], 1);
        check("t2_pair_count", pair_count, 2);
        check("t2_error_count", error_count, 1);

        // Back-pressure: exactly one pair held, stable, then the rest drain back-to-back.
        out_ready = 1'b0;
        base = pop_cnt;
        for (int i = 0; i < 3; i++) push_pair($urandom, 3'd0);
        tick(2);
        check("t3_held_valid", out_valid, 1);
        check("t3_held_result_a", out_result, exp_q[0].r);
        tick(8);
        check("t3_one_pop", pop_cnt - base, 1);
        check("t3_held_result_b", out_result, exp_q[0].r);
        check("t3_held_status_b", out_status, exp_q[0].s);
        pop_cycles.delete();
        out_ready = 1'b1;
        wait_drain("drain_t3", 50);
        tick(2);
        check("t3_release_pops", pop_cycles.size(), 2);
        if (pop_cycles.size() == 2) check("t3_release_consec", pop_cycles[1] - pop_cycles[0], 1);
        check("t3_pair_count", pair_count, model_pairs);

        // Reset mid-stream: held pair discarded, no pop while reset is high.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_pair($urandom, 3'($urandom_range(0, 7)));
        tick(3);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        check("t1_no_pop_in_reset", result_read, 0);
        check("t1_out_valid", out_valid, 0);
        check("t1_out_result", out_result, 0);
        check("t1_pair_count", pair_count, 0);
        check("t1_error_count", error_count, 0);
        tick();
        res_q.delete(); st_q.delete(); mres.delete(); mst.delete(); exp_q.delete();
        model_pairs = 0;
        model_errs  = 0;
        update_ports();
        tick();
        reset = 1'b0;
        tick(2);

        // Desync: result present, status missing for TIMEOUT cycles.
        base = pop_cnt;
        push_res(32'hA5A5_0001);
        tick(TIMEOUT - 1);
        check("t4_no_desync_early", sync_error, 0);
        tick();
        check("t4_desync_flag", sync_error, 1);
        push_st(3'd0);
        tick(10);
        check("t4_no_pops_desync", pop_cnt - base, 0);
        check("t4_sticky", sync_error, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_clear_sync", sync_error, 0);
        check("t4_clear_pairs", pair_count, 0);
        check("t4_clear_errs", error_count, 0);
        model_pairs = 1;
        model_errs  = 0;
        wait_drain("drain_t4", 50);
        tick(2);
        check("t4_resume_pairs", pair_count, model_pairs);

        // Clear beats a pop that would otherwise happen the same cycle.
        base = pop_cnt;
        push_pair(32'h1234_5678, 3'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clear_wins", pair_count, 0);
        check("t5_no_pop_on_clear", pop_cnt - base, 0);
        model_pairs = 1;
        model_errs  = 0;
        wait_drain("drain_t5", 50);
        tick(2);
        check("t5_after_clear", pair_count, 1);

        // Random traffic with skewed pushes and random back-pressure; drives counters to saturation.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bit [RW-1:0] r;
            bit [SW-1:0] s;
            r = $urandom;
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                push_res(r);
                tick($urandom_range(1, 3));
                push_st(s);
            end else begin
                push_pair(r, s);
            end
            tick($urandom_range(1, 2));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain("drain_rand", 3000);
        tick(2);
        check("rand_pair_count", pair_count, model_pairs);
        check("rand_error_count", error_count, model_errs);
        check("rand_pair_sat", pair_count, CNT_MAX);
        check("rand_no_desync", sync_error, 0);
        check("rand_out_idle", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
